// File: rtl/box_draw_arbiter.sv
// Round-robin arbiter sharing one VGA plot port between two box-drawing requesters;
// the granted box is latched and rasterised row-major, one pixel per clock.
module box_draw_arbiter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 4,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [SIZE_W-1:0]   size0,
  input  logic [COLOUR_W-1:0] colour0,
  input  logic                req1,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y1,
  input  logic [SIZE_W-1:0]   size1,
  input  logic [COLOUR_W-1:0] colour1,
  output logic                grant0,
  output logic                grant1,
  output logic                done0,
  output logic                done1,
  output logic                busy,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [SIZE_W-1:0] SZ_ONE = SIZE_W'(1);

  state_t                state_q;
  logic                  last_q;
  logic [X_W-1:0]        bx_q;
  logic [Y_W-1:0]        by_q;
  logic [SIZE_W-1:0]     size_q, cx_q, cy_q;
  logic [COLOUR_W-1:0]   col_q;
  logic                  grant0_q, grant1_q, done0_q, done1_q, busy_q, plot_q;
  logic [X_W-1:0]        vga_x_q;
  logic [Y_W-1:0]        vga_y_q;
  logic [COLOUR_W-1:0]   vga_colour_q;

  logic [SIZE_W-1:0]     size_m1_d;
  logic                  pick0_d;

  // Coordinates wrap at the port width; there is no clipping to the screen.
  function automatic logic [X_W-1:0] pix_x(input logic [X_W-1:0] b, input logic [SIZE_W-1:0] c);
    return b + X_W'(c);
  endfunction

  function automatic logic [Y_W-1:0] pix_y(input logic [Y_W-1:0] b, input logic [SIZE_W-1:0] c);
    return b + Y_W'(c);
  endfunction

  assign size_m1_d = size_q - SZ_ONE;
  // On contention the requester not granted last wins (last_q=1 means 1 was last).
  assign pick0_d   = req0 && (!req1 || last_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      bx_q         <= '0;
      by_q         <= '0;
      size_q       <= '0;
      col_q        <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          plot_q  <= 1'b0;
          // First IDLE edge after a box only retires done/busy; requests wait one more edge.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (req0 || req1) begin
            busy_q   <= 1'b1;
            cx_q     <= '0;
            cy_q     <= '0;
            grant0_q <= pick0_d;
            grant1_q <= !pick0_d;
            last_q   <= !pick0_d;
            bx_q     <= pick0_d ? x0      : x1;
            by_q     <= pick0_d ? y0      : y1;
            size_q   <= pick0_d ? size0   : size1;
            col_q    <= pick0_d ? colour0 : colour1;
            state_q  <= ((pick0_d ? size0 : size1) == '0) ? DONE : DRAW;
          end
        end
        DRAW: begin
          plot_q       <= 1'b1;
          vga_x_q      <= pix_x(bx_q, cx_q);
          vga_y_q      <= pix_y(by_q, cy_q);
          vga_colour_q <= col_q;
          if (cx_q == size_m1_d) begin
            cx_q <= '0;
            cy_q <= cy_q + SZ_ONE;
            if (cy_q == size_m1_d) state_q <= DONE;
          end else begin
            cx_q <= cx_q + SZ_ONE;
          end
        end
        DONE: begin
          plot_q   <= 1'b0;
          grant0_q <= 1'b0;
          grant1_q <= 1'b0;
          done0_q  <= grant0_q;
          done1_q  <= grant1_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant0     = grant0_q;
  assign grant1     = grant1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign busy       = busy_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;

endmodule
